codec_play_sched: RTL and testbench
===================================

Name: codec_play_sched

Overview:
- Playback scheduler in front of the codec serial interface.
- Owns the codec's 16-bit lft_out/rht_out sample slot and shares it between two stereo sample producers: src0, the main audio/filter path, and src1, the tone/diagnostic path.
- Buffers each producer in a small FIFO and selects one stereo pair per codec frame, using a preferred source with optional fallback.
- Handles underrun by muting or by repeating the last sample, and counts underruns.

Parameters:
- DEPTH, 4, stereo entries per source FIFO; power of 2, minimum 2.
- UCNT_W, 8, width of the saturating underrun counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- en  input  1  scheduler enable; low = flush and mute
- pri  input  1  preferred source: 0 = src0, 1 = src1
- fallback_en  input  1  when preferred FIFO is empty, allow pop from the other source
- hold_en  input  1  on underrun: 1 = repeat last sample, 0 = output zero
- codec_valid  input  1  valid from codec interface; a rising edge marks the frame tick
- src0_vld  input  1  src0 push request
- src0_lft  input  16  src0 left sample
- src0_rht  input  16  src0 right sample
- src0_rdy  output  1  src0 FIFO can accept
- src1_vld, src1_lft, src1_rht, src1_rdy: same as src0, for src1
- lft_out  output  16  left sample to codec
- rht_out  output  16  right sample to codec
- cur_src  output  2  source of the current output: 0 = src0, 1 = src1, 2 = underrun-zero, 3 = underrun-hold
- underrun_cnt  output  UCNT_W  saturating underrun count
- running  output  1  state == RUN

Behaviour:
- Reset values:
  - lft_out = 0, rht_out = 0, cur_src = 2, underrun_cnt = 0, running = 0.
  - src0_rdy = 0, src1_rdy = 0.
  - Both FIFOs empty; state WAIT_SYNC; codec_valid delay flop = 1 (suppresses a false tick right after reset).
- Frame tick:
  - tick = codec_valid & ~codec_valid_d, with codec_valid_d registered.
  - Exactly one tick per rising edge, independent of pulse width.
- States:
  - WAIT_SYNC:
    - Outputs held at zero; FIFOs accept pushes only when en = 1.
    - Move to RUN on the first tick with en = 1.
    - That first tick does not pop; it only aligns the scheduler to the frame.
  - RUN: every tick performs one selection (below).
  - Any state with en = 0:
    - Next state is WAIT_SYNC; both FIFOs flush (pointers and counts cleared); rdy = 0.
    - lft_out = rht_out = 0, cur_src = 2.
    - underrun_cnt retains its value.
- Selection on a tick in RUN (registered; outputs change 1 clk after the tick and hold until the next tick):
  - Preferred FIFO (chosen by pri) non-empty: pop its head; cur_src = pri.
  - Else if fallback_en and the other FIFO is non-empty: pop the other; cur_src = ~pri.
  - Else underrun:
    - hold_en = 1: outputs unchanged, cur_src = 3.
    - hold_en = 0: outputs = 0, cur_src = 2.
    - In both cases underrun_cnt increments, saturating at all-ones.
  - At most one FIFO pops per tick.
- FIFO rules (per source):
  - srcN_rdy = en & (count < DEPTH), taken from registered count.
  - Push when srcN_vld & srcN_rdy; left and right are stored as one entry.
  - Full FIFO refuses a push even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count is unchanged, both occur.
  - Push to an empty FIFO in the same cycle as a tick: no bypass; the tick sees empty and the data is used on the next tick.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Control inputs:
  - pri, fallback_en and hold_en are sampled on the tick cycle only.
  - Changing them between ticks has no effect until the next tick.
- Reset mid-operation: asynchronously returns everything to the reset values; in-flight FIFO data is discarded.

Test Plan:
- Basic path:
  - Stimulus: en = 1, pri = 0; push src0 pairs (0x1111, 0x2222), (0x3333, 0x4444); four codec_valid pulses.
  - Required: first tick only enters RUN; the next ticks give outputs 0x1111/0x2222, then 0x3333/0x4444, each 1 clk after its tick; the fourth tick underruns → outputs 0, cur_src = 2, underrun_cnt = 1.
- Priority and fallback:
  - Stimulus: pri = 1; src1 empty; src0 holds 0x0AAA/0x0BBB.
  - Required with fallback_en = 1: tick outputs 0x0AAA/0x0BBB, cur_src = 0.
  - Required with fallback_en = 0: underrun, src0 count unchanged.
- Hold on underrun:
  - Stimulus: hold_en = 1 after output 0x1234/0x5678; both FIFOs empty; tick.
  - Required: outputs stay 0x1234/0x5678, cur_src = 3, underrun_cnt increments.
  - Additional: force 300 underruns → underrun_cnt saturates at 0xFF.
- Full FIFO:
  - Stimulus: push 5 entries to src0 with no ticks; then one tick with src0_vld held high.
  - Required: src0_rdy drops after the 4th entry; the 5th is not accepted until the cycle after the pop; the popped entry is the 1st pushed (FIFO order preserved across pointer wrap).
- Enable drop mid-stream:
  - Stimulus: en → 0 with 3 entries queued.
  - Required: next clk gives rdy = 0, outputs 0, running = 0; after en → 1 the FIFOs are empty; the first tick realigns without popping.
- Long and double pulses:
  - Stimulus: codec_valid held high for 40 clks; separately, a push coinciding with a tick on an empty FIFO.
  - Required: exactly one pop per rising edge; the coincident push gives an underrun on that tick and the data on the next tick.

Source files
------------

// File: rtl/codec_play_sched.sv
// Playback scheduler for the codec sample slot: two buffered stereo producers,
// one pair selected per codec frame with priority, fallback and underrun handling.

module CodecPlayFifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_push_req,
    input  logic [15:0] i_push_lft,
    input  logic [15:0] i_push_rht,
    input  logic        i_pop,
    output logic        o_rdy,
    output logic        o_empty,
    output logic [15:0] o_head_lft,
    output logic [15:0] o_head_rht
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Readiness comes from the registered count, so a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    assign o_rdy      = i_en & (r_count < CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push_req & o_rdy;
    assign w_pop      = i_pop & ~o_empty;
    assign o_head_lft = r_mem[r_rd_ptr][31:16];
    assign o_head_rht = r_mem[r_rd_ptr][15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!i_en) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_push_lft, i_push_rht};
    end
endmodule

module codec_play_sched #(
    parameter int DEPTH  = 4,
    parameter int UCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pri,
    input  logic              fallback_en,
    input  logic              hold_en,
    input  logic              codec_valid,
    input  logic              src0_vld,
    input  logic [15:0]       src0_lft,
    input  logic [15:0]       src0_rht,
    output logic              src0_rdy,
    input  logic              src1_vld,
    input  logic [15:0]       src1_lft,
    input  logic [15:0]       src1_rht,
    output logic              src1_rdy,
    output logic [15:0]       lft_out,
    output logic [15:0]       rht_out,
    output logic [1:0]        cur_src,
    output logic [UCNT_W-1:0] underrun_cnt,
    output logic              running
);
    typedef enum logic {WAIT_SYNC, RUN} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_cv_d;
    logic              w_tick;
    logic              w_sel_tick;
    logic              w_pop0;
    logic              w_pop1;
    logic              w_underrun;
    logic              w_empty0;
    logic              w_empty1;
    logic [15:0]       w_head0_lft;
    logic [15:0]       w_head0_rht;
    logic [15:0]       w_head1_lft;
    logic [15:0]       w_head1_rht;
    logic [15:0]       r_lft;
    logic [15:0]       r_rht;
    logic [1:0]        r_cur;
    logic [UCNT_W-1:0] r_ucnt;

    CodecPlayFifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_push_req (src0_vld),
        .i_push_lft (src0_lft),
        .i_push_rht (src0_rht),
        .i_pop      (w_pop0),
        .o_rdy      (src0_rdy),
        .o_empty    (w_empty0),
        .o_head_lft (w_head0_lft),
        .o_head_rht (w_head0_rht)
    );

    CodecPlayFifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_push_req (src1_vld),
        .i_push_lft (src1_lft),
        .i_push_rht (src1_rht),
        .i_pop      (w_pop1),
        .o_rdy      (src1_rdy),
        .o_empty    (w_empty1),
        .o_head_lft (w_head1_lft),
        .o_head_rht (w_head1_rht)
    );

    // The delay flop resets high so a codec_valid already high at reset release is not a tick.
    assign w_tick     = codec_valid & ~r_cv_d;
    assign w_sel_tick = (r_state == RUN) & en & w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_SYNC;
            r_cv_d  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_cv_d  <= codec_valid;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!en) begin
            w_next_state = WAIT_SYNC;
        end else if (r_state == WAIT_SYNC && w_tick) begin
            w_next_state = RUN;
        end
    end

    always_comb begin
        w_pop0     = 1'b0;
        w_pop1     = 1'b0;
        w_underrun = 1'b0;
        if (w_sel_tick) begin
            if (!pri && !w_empty0) begin
                w_pop0 = 1'b1;
            end else if (pri && !w_empty1) begin
                w_pop1 = 1'b1;
            end else if (fallback_en && !pri && !w_empty1) begin
                w_pop1 = 1'b1;
            end else if (fallback_en && pri && !w_empty0) begin
                w_pop0 = 1'b1;
            end else begin
                w_underrun = 1'b1;
            end
        end
    end

    // Output pair and source tag only move on a selecting tick; disable forces mute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft  <= '0;
            r_rht  <= '0;
            r_cur  <= 2'd2;
            r_ucnt <= '0;
        end else if (!en) begin
            r_lft <= '0;
            r_rht <= '0;
            r_cur <= 2'd2;
        end else if (w_pop0) begin
            r_lft <= w_head0_lft;
            r_rht <= w_head0_rht;
            r_cur <= 2'd0;
        end else if (w_pop1) begin
            r_lft <= w_head1_lft;
            r_rht <= w_head1_rht;
            r_cur <= 2'd1;
        end else if (w_underrun) begin
            if (hold_en) begin
                r_cur <= 2'd3;
            end else begin
                r_lft <= '0;
                r_rht <= '0;
                r_cur <= 2'd2;
            end
            if (r_ucnt != '1) r_ucnt <= r_ucnt + 1'b1;
        end
    end

    assign lft_out      = r_lft;
    assign rht_out      = r_rht;
    assign cur_src      = r_cur;
    assign underrun_cnt = r_ucnt;
    assign running      = (r_state == RUN);
endmodule

// File: tb/tb_codec_play_sched.sv
// Directed bench for codec_play_sched: a queue-based frame model checked every
// cycle, plus literal expectations at the interesting points of each scenario.

module tb_codec_play_sched;
    localparam int DEPTH = 4;
    localparam int UMAX  = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pri = 1'b0;
    logic        fallback_en = 1'b0;
    logic        hold_en = 1'b0;
    logic        codec_valid = 1'b1;
    logic        src0_vld = 1'b0;
    logic [15:0] src0_lft = '0;
    logic [15:0] src0_rht = '0;
    logic        src1_vld = 1'b0;
    logic [15:0] src1_lft = '0;
    logic [15:0] src1_rht = '0;
    logic        src0_rdy;
    logic        src1_rdy;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic [1:0]  cur_src;
    logic [7:0]  underrun_cnt;
    logic        running;

    int checkCount = 0;
    int failCount  = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          mRun;
    bit          mCvd;
    logic [15:0] mLft;
    logic [15:0] mRht;
    logic [1:0]  mCur;
    int          mUcnt;

    always #5 clk = ~clk;

    codec_play_sched #(.DEPTH(DEPTH), .UCNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pri          (pri),
        .fallback_en  (fallback_en),
        .hold_en      (hold_en),
        .codec_valid  (codec_valid),
        .src0_vld     (src0_vld),
        .src0_lft     (src0_lft),
        .src0_rht     (src0_rht),
        .src0_rdy     (src0_rdy),
        .src1_vld     (src1_vld),
        .src1_lft     (src1_lft),
        .src1_rht     (src1_rht),
        .src1_rdy     (src1_rdy),
        .lft_out      (lft_out),
        .rht_out      (rht_out),
        .cur_src      (cur_src),
        .underrun_cnt (underrun_cnt),
        .running      (running)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        q0.delete();
        q1.delete();
        mRun  = 1'b0;
        mCvd  = 1'b1;
        mLft  = '0;
        mRht  = '0;
        mCur  = 2'd2;
        mUcnt = 0;
    endtask

    task automatic takeEntry(input int src);
        if (src == 0) {mLft, mRht} = q0.pop_front();
        else          {mLft, mRht} = q1.pop_front();
        mCur = 2'(src);
    endtask

    // One frame-level step: a rising codec_valid either aligns or serves one pair,
    // and accepted pushes land behind anything popped this cycle.
    task automatic modelStep();
        bit tick;
        bit acc0;
        bit acc1;
        if (!rst_n) begin
            resetModel();
        end else begin
            tick = codec_valid && !mCvd;
            acc0 = src0_vld && en && (q0.size() < DEPTH);
            acc1 = src1_vld && en && (q1.size() < DEPTH);
            if (!en) begin
                q0.delete();
                q1.delete();
                mRun = 1'b0;
                mLft = '0;
                mRht = '0;
                mCur = 2'd2;
            end else if (tick && !mRun) begin
                mRun = 1'b1;
            end else if (tick) begin
                if (!pri && q0.size() != 0)                     takeEntry(0);
                else if (pri && q1.size() != 0)                 takeEntry(1);
                else if (fallback_en && !pri && q1.size() != 0) takeEntry(1);
                else if (fallback_en && pri && q0.size() != 0)  takeEntry(0);
                else begin
                    if (hold_en) mCur = 2'd3;
                    else begin
                        mLft = '0;
                        mRht = '0;
                        mCur = 2'd2;
                    end
                    if (mUcnt < UMAX) mUcnt++;
                end
            end
            if (acc0) q0.push_back({src0_lft, src0_rht});
            if (acc1) q1.push_back({src1_lft, src1_rht});
            mCvd = codec_valid;
        end
    endtask

    initial begin
        resetModel();
        forever begin
            @(posedge clk or negedge rst_n);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("m_lft_out", lft_out, mLft);
            checkOutput("m_rht_out", rht_out, mRht);
            checkOutput("m_cur_src", cur_src, mCur);
            checkOutput("m_underrun_cnt", underrun_cnt, mUcnt);
            checkOutput("m_running", running, mRun);
            checkOutput("m_src0_rdy", src0_rdy, en && (q0.size() < DEPTH));
            checkOutput("m_src1_rdy", src1_rdy, en && (q1.size() < DEPTH));
        end
    end

    initial begin
        #500000;
        failCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input bit v0, input logic [15:0] l0, input logic [15:0] r0,
                                 input bit v1, input logic [15:0] l1, input logic [15:0] r1,
                                 input bit cv);
        src0_vld    = v0;
        src0_lft    = l0;
        src0_rht    = r0;
        src1_vld    = v1;
        src1_lft    = l1;
        src1_rht    = r1;
        codec_valid = cv;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic push0(input logic [15:0] l, input logic [15:0] r);
        applyStimulus(1, l, r, 0, 16'h0, 16'h0, 0);
        idle(1);
    endtask

    task automatic push1(input logic [15:0] l, input logic [15:0] r);
        applyStimulus(0, 16'h0, 16'h0, 1, l, r, 0);
        idle(1);
    endtask

    task automatic pulseTick();
        applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        idle(1);
    endtask

    task automatic checkPair(input string name, input logic [15:0] l, input logic [15:0] r, input logic [1:0] src);
        checkOutput({name, "_lft"}, lft_out, l);
        checkOutput({name, "_rht"}, rht_out, r);
        checkOutput({name, "_src"}, cur_src, src);
    endtask

    initial begin
        logic [15:0] ent [5];
        ent = '{16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04, 16'h0E05};

        // Reset with codec_valid already high: release must not create a tick.
        repeat (3) @(negedge clk);
        checkPair("rst", 16'h0, 16'h0, 2'd2);
        checkOutput("rst_ucnt", underrun_cnt, 0);
        checkOutput("rst_running", running, 0);
        checkOutput("rst_rdy0", src0_rdy, 0);
        checkOutput("rst_rdy1", src1_rdy, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("no_false_tick", running, 0);
        idle(2);

        // Basic path
        push0(16'h1111, 16'h2222);
        push0(16'h3333, 16'h4444);
        pulseTick();
        checkOutput("align_running", running, 1);
        checkPair("align", 16'h0, 16'h0, 2'd2);
        pulseTick();
        checkPair("basic1", 16'h1111, 16'h2222, 2'd0);
        pulseTick();
        checkPair("basic2", 16'h3333, 16'h4444, 2'd0);
        pulseTick();
        checkPair("basic_under", 16'h0, 16'h0, 2'd2);
        checkOutput("basic_ucnt", underrun_cnt, 1);

        // Priority and fallback
        push0(16'h0AAA, 16'h0BBB);
        pri         = 1'b1;
        fallback_en = 1'b1;
        pulseTick();
        checkPair("fallback", 16'h0AAA, 16'h0BBB, 2'd0);
        push0(16'h0CCC, 16'h0DDD);
        fallback_en = 1'b0;
        pulseTick();
        checkPair("nofallback", 16'h0, 16'h0, 2'd2);
        checkOutput("nofallback_ucnt", underrun_cnt, 2);
        pri = 1'b0;
        pulseTick();
        checkPair("kept_entry", 16'h0CCC, 16'h0DDD, 2'd0);

        // Hold on underrun, then saturation; pri toggles between ticks
        push1(16'h1234, 16'h5678);
        pri = 1'b1;
        pulseTick();
        checkPair("src1_pop", 16'h1234, 16'h5678, 2'd1);
        hold_en = 1'b1;
        pulseTick();
        checkPair("hold", 16'h1234, 16'h5678, 2'd3);
        checkOutput("hold_ucnt", underrun_cnt, 3);
        for (int i = 0; i < 300; i++) begin
            pri = i[0];
            pulseTick();
        end
        checkOutput("ucnt_sat", underrun_cnt, UMAX);
        checkPair("hold_long", 16'h1234, 16'h5678, 2'd3);

        // Full FIFO, pop and refused push in one cycle, order across pointer wrap
        hold_en = 1'b0;
        pri     = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1, ent[i], ~ent[i], 0, 16'h0, 16'h0, 0);
        checkOutput("full_rdy0", src0_rdy, 0);
        applyStimulus(1, ent[4], ~ent[4], 0, 16'h0, 16'h0, 0);
        applyStimulus(1, ent[4], ~ent[4], 0, 16'h0, 16'h0, 1);
        checkPair("full_pop", ent[0], ~ent[0], 2'd0);
        checkOutput("after_pop_rdy0", src0_rdy, 1);
        applyStimulus(1, ent[4], ~ent[4], 0, 16'h0, 16'h0, 0);
        checkOutput("refill_rdy0", src0_rdy, 0);
        idle(1);
        for (int i = 1; i < 5; i++) begin
            pulseTick();
            checkPair("wrap_order", ent[i], ~ent[i], 2'd0);
        end

        // Enable drop with entries queued
        push0(16'h5001, 16'h5002);
        push0(16'h5003, 16'h5004);
        push1(16'h6001, 16'h6002);
        pulseTick();
        checkPair("pre_drop", 16'h5001, 16'h5002, 2'd0);
        en = 1'b0;
        @(negedge clk);
        checkOutput("drop_rdy0", src0_rdy, 0);
        checkOutput("drop_rdy1", src1_rdy, 0);
        checkOutput("drop_running", running, 0);
        checkPair("drop", 16'h0, 16'h0, 2'd2);
        checkOutput("drop_ucnt", underrun_cnt, UMAX);
        idle(2);
        en          = 1'b1;
        fallback_en = 1'b1;
        idle(2);
        pulseTick();
        checkOutput("realign_running", running, 1);
        checkPair("realign", 16'h0, 16'h0, 2'd2);
        pulseTick();
        checkPair("flushed", 16'h0, 16'h0, 2'd2);
        fallback_en = 1'b0;

        // Long codec_valid pulse, then push coinciding with a tick on an empty FIFO
        push0(16'hA001, 16'hA002);
        push0(16'hA003, 16'hA004);
        repeat (40) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        idle(1);
        checkPair("long_pulse", 16'hA001, 16'hA002, 2'd0);
        pulseTick();
        checkPair("long_next", 16'hA003, 16'hA004, 2'd0);
        applyStimulus(1, 16'hB001, 16'hB002, 0, 16'h0, 16'h0, 1);
        idle(1);
        checkPair("coincident", 16'h0, 16'h0, 2'd2);
        pulseTick();
        checkPair("coincident_next", 16'hB001, 16'hB002, 2'd0);

        // Asynchronous reset mid-operation discards queued data
        push0(16'hC001, 16'hC002);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        checkPair("async_rst", 16'h0, 16'h0, 2'd2);
        checkOutput("async_rst_ucnt", underrun_cnt, 0);
        checkOutput("async_rst_running", running, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        idle(2);
        pulseTick();
        checkOutput("post_rst_align", running, 1);
        pulseTick();
        checkPair("post_rst_under", 16'h0, 16'h0, 2'd2);
        checkOutput("post_rst_ucnt", underrun_cnt, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
